dmem_responder: RTL and testbench

Memory-side responder for the CPU's two memory ports. It holds a 2^ADDR_W x DATA_W storage array. Port A is a single-cycle registered instruction fetch port. Port B is a data port that serves CPU load/store requests through a req/ack handshake with a programmable number of wait states. It replaces the zero-latency dual-port memory when the core is exercised against slow data memory.

---
 rtl/dmem_responder.sv | 166 ++++++++++++++++
 tb/tb_dmem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the CPU's two memory ports. It holds a
//   2^ADDR_W x DATA_W array with a registered single-cycle instruction fetch
//   port (A) and a req/ack data port (B) that inserts WAIT_CYCLES wait states
//   before each access.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset; clears the array and aborts
//               any transaction in flight
//   instr_addr  port-A fetch address
//   instr_out   port-A fetch data, one cycle after the address
//   req         port-B request, sampled only while idle
//   we          port-B 1 = store, 0 = load (latched with req)
//   addr        port-B address (latched with req)
//   wdata       port-B store data (latched with req)
//   ack         one-cycle completion pulse
//   rdata       load data, valid with ack and held afterwards
//   busy        high whenever a port-B transaction is in progress
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic [DATA_W-1:0] instr_out,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [3:0]          cnt_r;
    logic [3:0]          cnt_next_s;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic                accept_s;
    logic                access_s;
    logic                op_we_s;
    logic [ADDR_W-1:0]   op_addr_s;
    logic [DATA_W-1:0]   op_wdata_s;
    logic                ack_r;
    logic                busy_r;
    logic [DATA_W-1:0]   rdata_r;
    logic [DATA_W-1:0]   instr_out_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];

    // Next-state logic, request acceptance and access strobe for port B.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        access_s     = 1'b0;
        op_we_s      = we_r;
        op_addr_s    = addr_r;
        op_wdata_s   = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (req) begin
                    accept_s = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        // No wait states: the access happens on the
                        // acceptance edge, so the operands come straight
                        // from the inputs rather than the latches.
                        access_s     = 1'b1;
                        op_we_s      = we;
                        op_addr_s    = addr;
                        op_wdata_s   = wdata;
                        state_next_s = ST_RESP;
                    end else begin
                        cnt_next_s   = CNT_LOAD;
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_next_s = cnt_r - 4'd1;
                if (cnt_r == 4'd1) begin
                    access_s     = 1'b1;
                    state_next_s = ST_RESP;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // Port-B state, request latches and registered handshake/load outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 4'd0;
            we_r    <= 1'b0;
            addr_r  <= {ADDR_W{1'b0}};
            wdata_r <= {DATA_W{1'b0}};
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
            rdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            if (accept_s) begin
                we_r    <= we;
                addr_r  <= addr;
                wdata_r <= wdata;
            end
            // ack and busy are registered from the next state so they line
            // up exactly with RESP and with WAIT/RESP respectively.
            ack_r  <= (state_next_s == ST_RESP);
            busy_r <= (state_next_s != ST_IDLE);
            if (access_s && !op_we_s) begin
                rdata_r <= mem_r[op_addr_s];
            end
        end
    end

    // Storage array: port-A fetch and port-B store. The fetch reads the
    // pre-edge contents, giving read-before-write on a same-address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {DATA_W{1'b0}};
            end
            instr_out_r <= {DATA_W{1'b0}};
        end else begin
            instr_out_r <= mem_r[instr_addr];
            if (access_s && op_we_s) begin
                mem_r[op_addr_s] <= op_wdata_s;
            end
        end
    end

    assign instr_out = instr_out_r;
    assign ack       = ack_r;
    assign rdata     = rdata_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Drives three dmem_responder instances (WAIT_CYCLES = 0, 2, 3) with the
//   same stimulus and checks each one every cycle against a transaction-level
//   reference model: a transaction accepted at edge n accesses memory at edge
//   n + W, acks in the following cycle and lets the next request be sampled
//   at edge n + W + 2. Directed sections add literal expectations.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] instr_addr;
    logic       req;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;

    logic [7:0] instr_out_w [3];
    logic       ack_w       [3];
    logic [7:0] rdata_w     [3];
    logic       busy_w      [3];

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_w0 (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_out(instr_out_w[0]),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_w[0]), .rdata(rdata_w[0]), .busy(busy_w[0]));

    dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(2)) u_w2 (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_out(instr_out_w[1]),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_w[1]), .rdata(rdata_w[1]), .busy(busy_w[1]));

    dmem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(3)) u_w3 (
        .clk(clk), .rst(rst), .instr_addr(instr_addr), .instr_out(instr_out_w[2]),
        .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack_w[2]), .rdata(rdata_w[2]), .busy(busy_w[2]));

    function automatic int wc_of(input int k);
        case (k)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_mem   [3][256];
    logic [7:0] m_instr [3];
    logic [7:0] m_rdata [3];
    logic       m_ack   [3];
    logic       m_busy  [3];
    int         m_acc   [3];
    logic       m_we    [3];
    logic [7:0] m_addr  [3];
    logic [7:0] m_wdata [3];
    int         cyc_n    = 0;
    bit         model_ok = 1'b0;

    // Model update at every rising edge, from the sampled inputs.
    always @(posedge clk) begin
        cyc_n++;
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                for (int a = 0; a < 256; a++) m_mem[k][a] = 8'h00;
                m_instr[k] = 8'h00;
                m_rdata[k] = 8'h00;
                m_acc[k]   = -1000;
            end else begin
                m_instr[k] = m_mem[k][instr_addr];
                if (cyc_n >= m_acc[k] + wc_of(k) + 2 && req) begin
                    m_acc[k]   = cyc_n;
                    m_we[k]    = we;
                    m_addr[k]  = addr;
                    m_wdata[k] = wdata;
                end
                if (cyc_n == m_acc[k] + wc_of(k)) begin
                    if (m_we[k]) m_mem[k][m_addr[k]] = m_wdata[k];
                    else         m_rdata[k] = m_mem[k][m_addr[k]];
                end
            end
            m_ack[k]  = (cyc_n == m_acc[k] + wc_of(k));
            m_busy[k] = (cyc_n >= m_acc[k]) && (cyc_n <= m_acc[k] + wc_of(k));
        end
        model_ok = 1'b1;
    end

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("w%0d.instr_out", wc_of(k)), instr_out_w[k], m_instr[k]);
                chk($sformatf("w%0d.rdata", wc_of(k)), rdata_w[k], m_rdata[k]);
                chk($sformatf("w%0d.ack", wc_of(k)), ack_w[k], m_ack[k]);
                chk($sformatf("w%0d.busy", wc_of(k)), busy_w[k], m_busy[k]);
            end
        end
    end

    // One port-B transaction, then enough idle cycles for every instance.
    task automatic txn(input logic w, input logic [7:0] a, input logic [7:0] d);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    int acks [3];

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 8'h00; wdata = 8'h00;
        instr_addr = 8'h10;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset.instr_out", instr_out_w[1], 8'h00);
        chk("reset.ack", ack_w[1], 0);
        chk("reset.busy", busy_w[1], 0);
        chk("reset.rdata", rdata_w[1], 8'h00);

        // Store 0x5A to 0x20 with explicit timing on the W=2 instance.
        req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 8'h5A;
        @(negedge clk);                       // after E0
        chk("store.busy_e0", busy_w[1], 1);
        chk("store.ack_e0", ack_w[1], 0);
        req = 1'b0;
        @(negedge clk);                       // after E0+1
        chk("store.busy_e1", busy_w[1], 1);
        chk("store.ack_e1", ack_w[1], 0);
        @(negedge clk);                       // after E0+2
        chk("store.busy_e2", busy_w[1], 1);
        chk("store.ack_e2", ack_w[1], 1);
        @(negedge clk);                       // after E0+3
        chk("store.busy_e3", busy_w[1], 0);
        chk("store.ack_e3", ack_w[1], 0);
        repeat (3) @(negedge clk);
        txn(1'b0, 8'h20, 8'h00);
        chk("load_0x20", rdata_w[1], 8'h5A);

        // Port A after a store, then a same-address collision.
        txn(1'b1, 8'h40, 8'hC3);
        instr_addr = 8'h40;
        @(negedge clk);
        chk("porta_0x40", instr_out_w[1], 8'hC3);
        req = 1'b1; we = 1'b1; addr = 8'h40; wdata = 8'h11;
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        @(negedge clk);                       // after access edge E0+2
        chk("collide_old", instr_out_w[1], 8'hC3);
        @(negedge clk);
        chk("collide_new", instr_out_w[1], 8'h11);
        repeat (4) @(negedge clk);

        // Input isolation: inputs change after acceptance.
        req = 1'b1; we = 1'b1; addr = 8'h30; wdata = 8'h77;
        @(negedge clk);
        req = 1'b0; addr = 8'h31; wdata = 8'hFF;
        repeat (6) @(negedge clk);
        txn(1'b0, 8'h30, 8'h00);
        chk("isolate_0x30", rdata_w[1], 8'h77);
        txn(1'b0, 8'h31, 8'h00);
        chk("isolate_0x31", rdata_w[1], 8'h00);

        // Reset during WAIT aborts the store.
        req = 1'b1; we = 1'b1; addr = 8'h50; wdata = 8'hAA;
        @(negedge clk);
        req = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort.no_ack", ack_w[1], 0);
        end
        txn(1'b0, 8'h50, 8'h00);
        chk("abort.load_0x50", rdata_w[1], 8'h00);

        // Randomized traffic on a small address window to force reuse.
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            req        = 1'($urandom_range(0, 1));
            we         = 1'($urandom_range(0, 1));
            addr       = 8'($urandom_range(0, 15));
            wdata      = 8'($urandom);
            instr_addr = 8'($urandom_range(0, 15));
            @(negedge clk);
        end
        rst = 1'b0; req = 1'b0;
        repeat (8) @(negedge clk);

        // Back-to-back loads with req held high for 20 edges.
        for (int k = 0; k < 3; k++) acks[k] = 0;
        req = 1'b1; we = 1'b0;
        for (int i = 0; i < 20; i++) begin
            addr       = 8'($urandom_range(0, 15));
            instr_addr = 8'($urandom_range(0, 15));
            @(negedge clk);
            for (int k = 0; k < 3; k++) if (ack_w[k]) acks[k]++;
        end
        req = 1'b0;
        chk("b2b.w0_acks", acks[0], 10);
        chk("b2b.w2_acks", acks[1], 5);
        chk("b2b.w3_acks", acks[2], 4);
        repeat (8) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
